// File: rtl/shift_repeat_stage.sv
// Repeated shift/invert stage: applies one of SHL/SHR/SRA/NOT to a latched operand once per clock,
// in_count times, then holds the result on a valid/ready output. Optional parity output under SHIFT_REPEAT_PARITY_EN.
module shift_repeat_stage #(
   parameter int WIDTH = 9,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   input  logic [CNT_W-1:0] in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
`ifdef SHIFT_REPEAT_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [1:0] OP_SHL = 2'd0;
   localparam logic [1:0] OP_SHR = 2'd1;
   localparam logic [1:0] OP_SRA = 2'd2;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             rdy_q;
   logic             load;

   function automatic logic [WIDTH-1:0] apply(input logic [1:0] op, input logic [WIDTH-1:0] a);
      case (op)
         OP_SHL:  apply = {a[WIDTH-2:0], 1'b0};
         OP_SHR:  apply = {1'b0, a[WIDTH-1:1]};
         OP_SRA:  apply = {a[WIDTH-1], a[WIDTH-1:1]};
         default: apply = ~a;
      endcase
   endfunction

   // rdy_q keeps in_ready low through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         op_q    <= '0;
         rem_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      op_d     = op_q;
      rem_d    = rem_q;
      in_ready = rdy_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
      load     = in_valid & in_ready;

      case (state_q)
         RUN: begin
            acc_d = apply(op_q, acc_q);
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: ;
      endcase

      // A new operation overrides the IDLE/DONE defaults, including the same-cycle output handshake.
      if (load) begin
         acc_d   = in_data;
         op_d    = in_op;
         rem_d   = in_count;
         state_d = (in_count == '0) ? DONE : RUN;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign out_data  = acc_q;

`ifdef SHIFT_REPEAT_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= ^acc_d;
   end

   assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_shift_repeat_stage.sv
// Self-checking bench for shift_repeat_stage: directed scenarios plus a randomized stream
// checked against a closed-form reference model.
module tb_shift_repeat_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_data;
   logic [1:0] in_op;
   logic [3:0] in_count;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_data;
   logic       busy;
`ifdef SHIFT_REPEAT_PARITY_EN
   logic       out_parity;
   logic       last_par;
`endif

   int vectors = 0;
   int errors  = 0;

   shift_repeat_stage #(.WIDTH(9), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_op(in_op), .in_count(in_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
`ifdef SHIFT_REPEAT_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;

   // Reference: result of applying op n times, computed directly from the operation rules.
   function automatic logic [8:0] model(input int op, input logic [8:0] d, input int n);
      logic signed [8:0] s;
      s = d;
      case (op)
         0:       return d << n;
         1:       return d >> n;
         2:       return s >>> n;
         default: return (n % 2) ? ~d : d;
      endcase
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Offers an operation until accepted; returns just after the accepting edge with in_valid dropped.
   task automatic accept(input int op, input logic [8:0] d, input int n, output bit ok);
      ok = 0;
      in_valid = 1'b1; in_op = 2'(op); in_data = d; in_count = 4'(n);
      for (int i = 0; i < 50; i++) begin
         #1;
         if (in_ready) begin ok = 1; break; end
         step();
      end
      if (ok) step();
      in_valid = 1'b0;
   endtask

   // Runs one operation with out_ready high; returns observed result and accept-to-valid latency.
   task automatic run_op(input int op, input logic [8:0] d, input int n,
                         output logic [8:0] got, output int lat);
      bit ok;
      out_ready = 1'b1;
      accept(op, d, n, ok);
      lat = 1;
      while (!out_valid && lat < 40) begin step(); lat++; end
      got = out_data;
`ifdef SHIFT_REPEAT_PARITY_EN
      last_par = out_parity;
`endif
      step();
   endtask

   task automatic test_reset();
      bit ok;
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; in_count = '0; out_ready = 1'b0;
      #12;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 9'h000 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b busy=%b data=%h ready=%b want 0 0 000 0",
                  out_valid, busy, out_data, in_ready);
      end
      rst_n = 1'b1;
      step();
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", in_ready); end
      accept(3, 9'h1FF, 5, ok);
      step();
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_run: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 9'h000 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run: valid=%b busy=%b data=%h ready=%b want 0 0 000 0",
                  out_valid, busy, out_data, in_ready);
      end
      #3 rst_n = 1'b1;
      step();
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rerelease: got %b want 1", in_ready); end
      seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen++;
         step();
      end
      vectors++;
      if (seen != 0) begin errors++; $display("FAIL no_result_after_reset: saw %0d valid cycles want 0", seen); end
   endtask

   task automatic test_shl();
      logic [8:0] got;
      int lat;
      run_op(0, 9'h001, 3, got, lat);
      vectors++;
      if (got !== 9'h008) begin errors++; $display("FAIL shl3_data: got %h want 008", got); end
      vectors++;
      if (lat != 4) begin errors++; $display("FAIL shl3_latency: got %0d want 4", lat); end
      run_op(0, 9'h001, 9, got, lat);
      vectors++;
      if (got !== 9'h000) begin errors++; $display("FAIL shl9_data: got %h want 000", got); end
      run_op(0, 9'h0B5, 15, got, lat);
      vectors++;
      if (lat != 16) begin errors++; $display("FAIL shl15_latency: got %0d want 16", lat); end
   endtask

   task automatic test_sra_shr();
      logic [8:0] got;
      int lat;
      run_op(2, 9'h100, 2, got, lat);
      vectors++;
      if (got !== 9'h1C0) begin errors++; $display("FAIL sra2_data: got %h want 1c0", got); end
      run_op(1, 9'h100, 2, got, lat);
      vectors++;
      if (got !== 9'h040) begin errors++; $display("FAIL shr2_data: got %h want 040", got); end
      run_op(2, 9'h123, 15, got, lat);
      vectors++;
      if (got !== 9'h1FF) begin errors++; $display("FAIL sra15_saturate: got %h want 1ff", got); end
   endtask

   task automatic test_not_zero();
      logic [8:0] got;
      int lat;
      run_op(3, 9'h0AA, 0, got, lat);
      vectors++;
      if (got !== 9'h0AA || lat != 1) begin
         errors++; $display("FAIL not0: got %h lat %0d want 0aa lat 1", got, lat);
      end
      run_op(3, 9'h0AA, 2, got, lat);
      vectors++;
      if (got !== 9'h0AA) begin errors++; $display("FAIL not2: got %h want 0aa", got); end
      run_op(3, 9'h0AA, 1, got, lat);
      vectors++;
      if (got !== 9'h155) begin errors++; $display("FAIL not1: got %h want 155", got); end
`ifdef SHIFT_REPEAT_PARITY_EN
      vectors++;
      if (last_par !== 1'b1) begin errors++; $display("FAIL not1_parity: got %b want 1", last_par); end
`endif
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [8:0] held;
      int w;
      out_ready = 1'b0;
      accept(0, 9'h003, 2, ok);
      w = 0;
      while (!out_valid && w < 40) begin step(); w++; end
      held = out_data;
      vectors++;
      if (held !== 9'h00C) begin errors++; $display("FAIL bp_data: got %h want 00c", held); end
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== 9'h00C || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: valid=%b data=%h ready=%b want 1 00c 0", out_valid, out_data, in_ready);
         end
      end
      out_ready = 1'b1; in_valid = 1'b1; in_op = 2'd1; in_count = 4'd1; in_data = 9'h004;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follow: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL bp_dual_hs: valid=%b busy=%b want 0 1", out_valid, busy);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 9'h002) begin
         errors++; $display("FAIL bp_next_result: valid=%b data=%h want 1 002", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_q[$];
      int ops[8], cnts[8];
      logic [8:0] dats[8];
      logic [8:0] want;
      int sent, rcvd;
      bit hs_in, hs_out;
      for (int i = 0; i < 8; i++) begin
         ops[i]  = $urandom_range(3, 0);
         cnts[i] = $urandom_range(15, 0);
         dats[i] = 9'($urandom);
      end
      cnts[1] = 0; cnts[2] = 0;
      sent = 0; rcvd = 0;
      for (int cyc = 0; cyc < 2000 && rcvd < 8; cyc++) begin
         out_ready = 1'($urandom);
         if (sent < 8) begin
            in_valid = 1'b1; in_op = 2'(ops[sent]); in_data = dats[sent]; in_count = 4'(cnts[sent]);
         end else in_valid = 1'b0;
         #1;
         hs_in  = in_valid & in_ready;
         hs_out = out_valid & out_ready;
         if (hs_out) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'hxxx;
            vectors++;
            if (out_data !== want) begin
               errors++; $display("FAIL stream_result[%0d]: got %h want %h", rcvd, out_data, want);
            end
            rcvd++;
         end
         if (hs_in) begin
            exp_q.push_back(model(ops[sent], dats[sent], cnts[sent]));
            sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      vectors++;
      if (rcvd != 8 || exp_q.size() != 0) begin
         errors++; $display("FAIL stream_count: got %0d results, %0d pending want 8, 0", rcvd, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_shl();
      test_sra_shr();
      test_not_zero();
      test_backpressure();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
